onehot_rr_sched: RTL and testbench

ONEHOT_RR_SCHED -- requirements
Module: onehot_rr_sched

---
 rtl/onehot_rr_sched.sv | 180 ++++++++++++++++++
 tb/tb_onehot_rr_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_sched.sv
// onehot_rr_sched
//   Round-robin scheduler in front of a single shared one-hot encoder.
//   Up to NREQ requesters each present a W-bit word.  One winner is captured
//   per accept slot. Its word is encoded to a bit index, and the result is
//   held on a valid/ready output until the consumer takes it.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics.  A
//   result transfers on any rising edge where out_valid && out_ready.  While
//   out_valid && !out_ready, the signals out, out_id, out_err and out_valid
//   stay stable.  req[k] is a level that the requester holds until it sees
//   gnt[k].  gnt[k] is a one-cycle pulse, issued in the same cycle that the
//   captured result first appears on the output.
//
// Ports:
//   clk, rst_n     single rising-edge clock, synchronous active-low reset
//   req[NREQ]      per-requester request level
//   data_in        requester k word at data_in[k*W +: W]
//   gnt[NREQ]      one-hot grant pulse for the captured requester
//   out_valid      result valid
//   out_ready      consumer ready
//   out[N]         lowest set-bit index of the captured word (0 for zero word)
//   out_id         index of the requester that owns out
//   out_err        captured word was not exactly one-hot
//   err_cnt[8]     (only with ONEHOT_SCHED_ERR_CNT_EN) saturating count of
//                  transferred results that had out_err=1
//
// Optional feature macro: ONEHOT_SCHED_ERR_CNT_EN

module onehot_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int N    = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data_in,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out,
  output logic [IW-1:0]     out_id,
`ifdef ONEHOT_SCHED_ERR_CNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              out_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              out_valid_q, out_valid_d;
  logic [N-1:0]      out_q, out_d;
  logic [IW-1:0]     out_id_q, out_id_d;
  logic              out_err_q, out_err_d;

  logic [NREQ-1:0]   elig;
  logic              accept;
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [W-1:0]      win_word;
  logic [N-1:0]      enc_idx;
  logic              enc_hit;
  logic              enc_multi;
  logic              enc_err;

`ifdef ONEHOT_SCHED_ERR_CNT_EN
  logic [7:0]        err_cnt_q, err_cnt_d;
`endif

  always_comb begin
    // A requester whose grant is visible this cycle is still holding req.
    // Mask it so that it is not granted twice.
    elig   = req & ~gnt_q;
    accept = (state_q == IDLE) || out_ready;

    // Round-robin search starting at ptr_q and wrapping modulo NREQ.
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && elig[(int'(ptr_q) + i) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr_q) + i) % NREQ);
      end
    end

    win_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(win_idx) == k) win_word = data_in[k*W +: W];
    end

    // Encode the lowest set bit.  Flag the word as an error if it has no set
    // bit or more than one.
    enc_idx   = '0;
    enc_hit   = 1'b0;
    enc_multi = 1'b0;
    for (int b = 0; b < W; b++) begin
      if (win_word[b]) begin
        if (enc_hit) begin
          enc_multi = 1'b1;
        end else begin
          enc_idx = N'(b);
          enc_hit = 1'b1;
        end
      end
    end
    enc_err = !enc_hit || enc_multi;

    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_id_d    = out_id_q;
    out_err_d   = out_err_q;

    if (accept) begin
      if (win_found) begin
        state_d        = BUSY;
        out_valid_d    = 1'b1;
        gnt_d[win_idx] = 1'b1;
        out_d          = enc_idx;
        out_id_d       = win_idx;
        out_err_d      = enc_err;
        ptr_d          = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + IW'(1);
      end else begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    end

`ifdef ONEHOT_SCHED_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
    if (out_valid_q && out_ready && out_err_q && (err_cnt_q != 8'hff))
      err_cnt_d = err_cnt_q + 8'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_id_q    <= '0;
      out_err_q   <= 1'b0;
`ifdef ONEHOT_SCHED_ERR_CNT_EN
      err_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_id_q    <= out_id_d;
      out_err_q   <= out_err_d;
`ifdef ONEHOT_SCHED_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_id    = out_id_q;
  assign out_err   = out_err_q;
`ifdef ONEHOT_SCHED_ERR_CNT_EN
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_onehot_rr_sched.sv
// Testbench for onehot_rr_sched: directed scenarios followed by randomized
// traffic.  Outputs are compared each cycle against a behavioural model.
module tb_onehot_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int N    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data_in;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out;
  logic [1:0]        out_id;
  logic              out_err;
`ifdef ONEHOT_SCHED_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // behavioural model state
  int              m_ptr;
  bit              m_busy;
  logic [NREQ-1:0] m_gnt;
  int              m_out;
  int              m_id;
  bit              m_err;
  int              m_errcnt;
  logic [NREQ-1:0] rel;   // requesters that drop req at the next negedge

  onehot_rr_sched #(.NREQ(NREQ), .W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_id    (out_id),
`ifdef ONEHOT_SCHED_ERR_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .out_err   (out_err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int low_idx(input logic [W-1:0] w);
    logic [W-1:0] iso;
    if (w == '0) return 0;
    iso = w & (~w + 1'b1);
    return $clog2(iso);
  endfunction

  // Model of one rising edge using the current inputs.
  task automatic model_edge();
    logic [NREQ-1:0] elig;
    logic [W-1:0]    word;
    int              win;
    if (!rst_n) begin
      m_ptr = 0; m_busy = 0; m_gnt = '0; m_out = 0; m_id = 0; m_err = 0; m_errcnt = 0;
      return;
    end
    if (m_busy && out_ready && m_err && m_errcnt < 255) m_errcnt++;
    elig = req & ~m_gnt;
    m_gnt = '0;
    if (!m_busy || out_ready) begin
      win = -1;
      for (int i = 0; i < NREQ; i++)
        if (win < 0 && elig[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
      if (win >= 0) begin
        word       = data_in[win*W +: W];
        m_out      = low_idx(word);
        m_err      = ($countones(word) != 1);
        m_id       = win;
        m_ptr      = (win + 1) % NREQ;
        m_busy     = 1;
        m_gnt[win] = 1'b1;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("out_valid", 32'(out_valid), 32'(m_busy));
    check("out", 32'(out), 32'(m_out));
    check("out_id", 32'(out_id), 32'(m_id));
    check("out_err", 32'(out_err), 32'(m_err));
`ifdef ONEHOT_SCHED_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
  endtask

  // Driver: one clock cycle.  Inputs are applied at the negedge.  Outputs
  // are checked at the following negedge.  Granted requesters keep req
  // through the edge that ends their grant cycle, then release it.
  task automatic cycle(input logic rdy);
    out_ready = rdy;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    req = req & ~rel;
    rel = m_gnt;
  endtask

  task automatic set_slice(input int k, input logic [W-1:0] v);
    data_in[k*W +: W] = v;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; data_in = '0; out_ready = 1'b0; rel = '0;
    m_ptr = 0; m_busy = 0; m_gnt = '0; m_out = 0; m_id = 0; m_err = 0; m_errcnt = 0;
    @(negedge clk);
    cycle(1'b0);
    cycle(1'b0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_id", 32'(out_id), 32'h0);
    check("rst_err", 32'(out_err), 32'h0);
    rst_n = 1'b1;

    // round-robin, all four requesting, release on grant
    for (int k = 0; k < NREQ; k++) set_slice(k, W'(1) << k);
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      cycle(1'b1);
      check("rr_id", 32'(out_id), 32'(i));
      check("rr_gnt", 32'(gnt), 32'(1 << i));
      check("rr_valid", 32'(out_valid), 32'h1);
    end
    cycle(1'b1);
    check("rr_drain_valid", 32'(out_valid), 32'h0);

    // single request
    set_slice(0, 16'h0004);
    req = 4'b0001;
    cycle(1'b1);
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_out", 32'(out), 32'h2);
    check("single_id", 32'(out_id), 32'h0);
    check("single_err", 32'(out_err), 32'h0);
    cycle(1'b1);
    cycle(1'b1);

    // backpressure, with further requesters waiting
    set_slice(1, 16'h0010);
    req = 4'b0010;
    cycle(1'b1);
    check("bp_gnt", 32'(gnt), 32'h2);
    set_slice(2, 16'h0000);
    set_slice(3, 16'h0006);
    req = req | 4'b1100;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      check("bp_out", 32'(out), 32'h4);
      check("bp_id", 32'(out_id), 32'h1);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_nognt", 32'(gnt), 32'h0);
    end

    // error words
    cycle(1'b1);
    check("zero_out", 32'(out), 32'h0);
    check("zero_err", 32'(out_err), 32'h1);
    check("zero_id", 32'(out_id), 32'h2);
    cycle(1'b1);
    check("multi_out", 32'(out), 32'h1);
    check("multi_err", 32'(out_err), 32'h1);
    check("multi_id", 32'(out_id), 32'h3);
    cycle(1'b1);
    cycle(1'b1);
`ifdef ONEHOT_SCHED_ERR_CNT_EN
    check("err_cnt_two", 32'(err_cnt), 32'h2);
`endif

    // reset in the middle of a stalled result
    set_slice(1, 16'h0010);
    req = 4'b0010;
    cycle(1'b1);
    cycle(1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    cycle(1'b0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_gnt", 32'(gnt), 32'h0);
    set_slice(1, 16'h0100);
    set_slice(2, 16'h0001);
    req = 4'b0110; rel = '0;
    cycle(1'b1);
    check("inrst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    cycle(1'b1);
    check("postrst_gnt", 32'(gnt), 32'h2);
    check("postrst_id", 32'(out_id), 32'h1);
    check("postrst_out", 32'(out), 32'h8);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (!req[k] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: set_slice(k, W'(1) << $urandom_range(0, W - 1));
            6:                set_slice(k, '0);
            default:          set_slice(k, W'($urandom));
          endcase
          req[k] = 1'b1;
        end
      end
      cycle($urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
